// File: rtl/bus_master_port_if.sv
// bus_master_port_if: serial system-bus signals between a master port and the arbiter/slaves
interface bus_master_port_if;
    logic m_request;
    logic m_grant;
    logic m_slave_select;
    logic m_valid;
    logic m_rw;
    logic m_addr_bit;
    logic m_wdata_bit;
    logic s_ready;
    logic s_rdata_bit;
    modport master(
        output m_request, m_slave_select, m_valid, m_rw, m_addr_bit, m_wdata_bit,
        input  m_grant, s_ready, s_rdata_bit
    );
    modport slave(
        input  m_request, m_slave_select, m_valid, m_rw, m_addr_bit, m_wdata_bit,
        output m_grant, s_ready, s_rdata_bit
    );
endinterface

// File: rtl/bus_master_port.sv
// bus_master_port: parallel local request to serial request/grant bus transaction
module bus_master_port #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [1:0]        slave_id,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] rdata,
    bus_master_port_if.master bus
);
    localparam int BW = $clog2(ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [BW-1:0] A_LAST = BW'(ADDR_W - 1);
    localparam logic [BW-1:0] D_LAST = BW'(DATA_W - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    typedef enum logic [2:0] {IDLE, REQ, SSEL, ADDR, WDATA, WAIT_ACK, RDATA, DONE} state_t;
    state_t            st;
    logic [BW-1:0]     bcnt;
    logic [TW-1:0]     tcnt;
    logic              err;
    logic              rw_q;
    logic [1:0]        sid_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    assign busy               = st != IDLE;
    assign done               = st == DONE;
    assign error              = err;
    assign bus.m_request      = st inside {REQ, SSEL, ADDR, WDATA, WAIT_ACK, RDATA};
    assign bus.m_slave_select = st == REQ ? sid_q[0] : st == SSEL ? sid_q[1] : 1'b0;
    assign bus.m_valid        = st inside {ADDR, WDATA};
    assign bus.m_rw           = bus.m_valid & rw_q;
    assign bus.m_addr_bit     = st == ADDR & a_q[0];
    assign bus.m_wdata_bit    = st == WDATA & d_q[0];
    // Transaction sequencer; address/data copies shift out LSB first, read data shifts in from the top
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= IDLE;
            bcnt  <= '0;
            tcnt  <= '0;
            err   <= 1'b0;
            rw_q  <= 1'b0;
            sid_q <= '0;
            a_q   <= '0;
            d_q   <= '0;
            rdata <= '0;
        end else begin
            case (st)
                IDLE: if (start) begin
                    rw_q  <= rw;
                    sid_q <= slave_id;
                    a_q   <= addr;
                    d_q   <= wdata;
                    tcnt  <= '0;
                    err   <= 1'b0;
                    st    <= REQ;
                end
                REQ: if (bus.m_grant) st <= SSEL;
                     else if (tcnt == T_LAST) begin err <= 1'b1; st <= DONE; end
                     else tcnt <= tcnt + 1'b1;
                SSEL: if (!bus.m_grant) begin err <= 1'b1; st <= DONE; end
                      else begin bcnt <= '0; st <= ADDR; end
                ADDR: if (!bus.m_grant) begin err <= 1'b1; st <= DONE; end
                      else begin
                          a_q  <= a_q >> 1;
                          bcnt <= bcnt == A_LAST ? '0 : bcnt + 1'b1;
                          if (bcnt == A_LAST) begin
                              tcnt <= '0;
                              st   <= rw_q ? WDATA : WAIT_ACK;
                          end
                      end
                WDATA: if (!bus.m_grant) begin err <= 1'b1; st <= DONE; end
                       else begin
                           d_q  <= d_q >> 1;
                           bcnt <= bcnt + 1'b1;
                           if (bcnt == D_LAST) st <= WAIT_ACK;
                       end
                WAIT_ACK: if (!bus.m_grant) begin err <= 1'b1; st <= DONE; end
                          else if (bus.s_ready) begin bcnt <= '0; st <= rw_q ? DONE : RDATA; end
                          else if (tcnt == T_LAST) begin err <= 1'b1; st <= DONE; end
                          else tcnt <= tcnt + 1'b1;
                RDATA: if (!bus.m_grant) begin err <= 1'b1; st <= DONE; end
                       else begin
                           rdata <= {bus.s_rdata_bit, rdata[DATA_W-1:1]};
                           bcnt  <= bcnt + 1'b1;
                           if (bcnt == D_LAST) st <= DONE;
                       end
                DONE: st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: directed checks of the serial bus master port
module tb_bus_master_port;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  slave_id = '0;
    logic [11:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        busy, done, error;
    logic [7:0]  rdata;
    int          checks = 0;
    int          failures = 0;
    int          cyc, vcnt, dones, cyc_done, bad, req_gap;
    logic [1:0]  ss;
    logic [11:0] a_seen;
    logic [7:0]  d_seen, rd_done;
    logic        err_done, req_done, val_done, rw_exp;
    logic [7:0]  rv;
    bus_master_port_if bus();
    bus_master_port #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .slave_id(slave_id),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .error(error),
        .rdata(rdata), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Bus monitor: records the serial stream and the state of outputs at done
    always @(negedge clk) begin
        if (busy) begin
            cyc++;
            if (cyc <= 2) ss[cyc-1] = bus.m_slave_select;
            if (cyc > 2 && bus.m_slave_select) bad++;
            if (!done && !bus.m_request) req_gap++;
            if (bus.m_valid) begin
                if (bus.m_rw !== rw_exp) bad++;
                if (vcnt < 12) begin
                    a_seen = {bus.m_addr_bit, a_seen[11:1]};
                    if (bus.m_wdata_bit) bad++;
                end else begin
                    d_seen = {bus.m_wdata_bit, d_seen[7:1]};
                    if (bus.m_addr_bit) bad++;
                end
                vcnt++;
            end else if (bus.m_addr_bit || bus.m_wdata_bit || bus.m_rw) bad++;
            if (done) begin
                dones++;
                cyc_done = cyc;
                err_done = error;
                req_done = bus.m_request;
                val_done = bus.m_valid;
                rd_done  = rdata;
            end
        end
    end
    task automatic go(input logic w, input logic [1:0] s, input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        rw = w; slave_id = s; addr = a; wdata = d; start = 1'b1; rw_exp = w;
        cyc = 0; vcnt = 0; dones = 0; bad = 0; req_gap = 0; ss = '0; a_seen = '0; d_seen = '0;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wait_done();
        int n;
        for (n = 0; n < 200; n++) begin
            @(posedge clk);
            if (dones != 0) break;
        end
        check("done_seen", n < 200, 1);
        @(negedge clk);
    endtask
    task automatic outputs_zero(input string tag);
        check(tag, {busy, done, error, rdata, bus.m_request, bus.m_slave_select, bus.m_valid,
                    bus.m_rw, bus.m_addr_bit, bus.m_wdata_bit}, 0);
    endtask
    initial begin
        bus.m_grant = 1'b1;
        bus.s_ready = 1'b1;
        bus.s_rdata_bit = 1'b0;
        #1 reset = 1'b1;
        #1 outputs_zero("reset_outputs");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("idle_busy", busy, 0);
        go(1'b1, 2'b10, 12'hA5C, 8'h3C);
        wait_done();
        check("wr_cycles", cyc_done, 24);
        check("wr_ssel", ss, 2'b10);
        check("wr_addr", a_seen, 12'hA5C);
        check("wr_data", d_seen, 8'h3C);
        check("wr_nvalid", vcnt, 20);
        check("wr_error", err_done, 0);
        check("wr_req_done", req_done, 0);
        check("wr_req_gap", req_gap, 0);
        check("wr_bad", bad, 0);
        check("wr_busy_after", busy, 0);
        bus.s_ready = 1'b0;
        rv = 8'hB6;
        go(1'b0, 2'b01, 12'h001, 8'h00);
        repeat (15) @(negedge clk);
        bus.s_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.s_ready = 1'b0;
            bus.s_rdata_bit = rv[i];
        end
        wait_done();
        check("rd_cycles", cyc_done, 25);
        check("rd_ssel", ss, 2'b01);
        check("rd_addr", a_seen, 12'h001);
        check("rd_nvalid", vcnt, 12);
        check("rd_rdata_done", rd_done, 8'hB6);
        check("rd_error", err_done, 0);
        check("rd_bad", bad, 0);
        check("rd_req_gap", req_gap, 0);
        repeat (3) @(negedge clk);
        check("rd_rdata_held", rdata, 8'hB6);
        check("rd_busy_after", busy, 0);
        bus.s_ready = 1'b1;
        bus.m_grant = 1'b0;
        go(1'b1, 2'b10, 12'h000, 8'h00);
        wait_done();
        check("to_cycles", cyc_done, 9);
        check("to_error", err_done, 1);
        check("to_req_done", req_done, 0);
        check("to_nvalid", vcnt, 0);
        check("to_dones", dones, 1);
        bus.m_grant = 1'b1;
        go(1'b1, 2'b11, 12'h0FF, 8'h55);
        repeat (6) @(negedge clk);
        bus.m_grant = 1'b0;
        wait_done();
        bus.m_grant = 1'b1;
        check("lg_cycles", cyc_done, 8);
        check("lg_error", err_done, 1);
        check("lg_nvalid", vcnt, 5);
        check("lg_valid_done", val_done, 0);
        check("lg_valid_after", bus.m_valid, 0);
        go(1'b1, 2'b10, 12'hA5C, 8'h3C);
        repeat (3) @(negedge clk);
        rw = 1'b0; slave_id = 2'b01; addr = 12'h123; wdata = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        check("sb_ssel", ss, 2'b10);
        check("sb_addr", a_seen, 12'hA5C);
        check("sb_data", d_seen, 8'h3C);
        check("sb_cycles", cyc_done, 24);
        check("sb_dones", dones, 1);
        check("sb_bad", bad, 0);
        go(1'b1, 2'b10, 12'hA5C, 8'h3C);
        repeat (16) @(negedge clk);
        check("rs_in_wdata", bus.m_valid, 1);
        #2 reset = 1'b1;
        #1 outputs_zero("rs_outputs");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rs_no_done", dones, 0);
        check("rs_idle", busy, 0);
        go(1'b1, 2'b01, 12'h3F0, 8'hC3);
        wait_done();
        check("rs_wr_addr", a_seen, 12'h3F0);
        check("rs_wr_data", d_seen, 8'hC3);
        check("rs_wr_ssel", ss, 2'b01);
        check("rs_wr_error", err_done, 0);
        check("rs_wr_cycles", cyc_done, 24);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
